// File: rtl/block_pos_ctrl.sv
// Block position sequencer: steps the on-screen block once per FRAME_DIV frame ticks from the sampled buttons.
// Optional `BLK_WRAP_EN: leaving the legal range wraps to the opposite limit instead of clamping.
module block_pos_ctrl #(
    parameter int STEP      = 4,
    parameter int FRAME_DIV = 1,
    parameter int X_MIN     = 10,
    parameter int X_MAX     = 1397,
    parameter int Y_MIN     = 10,
    parameter int Y_MAX     = 857,
    parameter int X_INIT    = 704,
    parameter int Y_INIT    = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [3:0]  btn,
    output logic [10:0] blkpos_x,
    output logic [9:0]  blkpos_y,
    output logic        moved
);

    typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

    localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic signed [11:0] STEP_X   = 12'(STEP);
    localparam logic signed [11:0] XMIN_S   = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S   = 12'(X_MAX);
    localparam logic signed [10:0] STEP_Y   = 11'(STEP);
    localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);

    state_t             state, state_next;
    logic [3:0]         btn_meta, btn_s, dir;
    logic [7:0]         div_cnt;
    logic [10:0]        nx, nx_next;
    logic [9:0]         ny, ny_next;
    logic signed [11:0] x_cand;
    logic signed [10:0] y_cand;

    // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= '0;
            btn_s    <= '0;
        end else begin
            btn_meta <= btn;
            btn_s    <= btn_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick && div_cnt == DIV_LAST) state_next = CALC_X;
            CALC_X:  state_next = CALC_Y;
            CALC_Y:  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ticks arriving while a commit is in flight are deliberately not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= '0;
        else if (state == IDLE && frame_tick)
            div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
    end

    // Sign bit of the widened candidate catches underflow below zero before the range check.
    always_comb begin
        x_cand = $signed({1'b0, blkpos_x});
        if (btn_s[1] && !btn_s[0])      x_cand = x_cand - STEP_X;
        else if (btn_s[0] && !btn_s[1]) x_cand = x_cand + STEP_X;
`ifdef BLK_WRAP_EN
        if (x_cand < XMIN_S)      nx_next = 11'(X_MAX);
        else if (x_cand > XMAX_S) nx_next = 11'(X_MIN);
        else                      nx_next = x_cand[10:0];
`else
        if (x_cand < XMIN_S)      nx_next = 11'(X_MIN);
        else if (x_cand > XMAX_S) nx_next = 11'(X_MAX);
        else                      nx_next = x_cand[10:0];
`endif
    end

    always_comb begin
        y_cand = $signed({1'b0, blkpos_y});
        if (dir[3] && !dir[2])      y_cand = y_cand - STEP_Y;
        else if (dir[2] && !dir[3]) y_cand = y_cand + STEP_Y;
`ifdef BLK_WRAP_EN
        if (y_cand < YMIN_S)      ny_next = 10'(Y_MAX);
        else if (y_cand > YMAX_S) ny_next = 10'(Y_MIN);
        else                      ny_next = y_cand[9:0];
`else
        if (y_cand < YMIN_S)      ny_next = 10'(Y_MIN);
        else if (y_cand > YMAX_S) ny_next = 10'(Y_MAX);
        else                      ny_next = y_cand[9:0];
`endif
    end

    // Outputs move only on the COMMIT edge; a reset mid-sequence discards nx/ny.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir      <= '0;
            nx       <= 11'(X_INIT);
            ny       <= 10'(Y_INIT);
            blkpos_x <= 11'(X_INIT);
            blkpos_y <= 10'(Y_INIT);
            moved    <= 1'b0;
        end else begin
            moved <= 1'b0;
            case (state)
                CALC_X: begin
                    dir <= btn_s;
                    nx  <= nx_next;
                end
                CALC_Y: ny <= ny_next;
                COMMIT: begin
                    blkpos_x <= nx;
                    blkpos_y <= ny;
                    moved    <= (nx != blkpos_x) || (ny != blkpos_y);
                end
                default: ;
            endcase
        end
    end

endmodule
